// File: rtl/dht_pkg.sv
// rtl/dht_pkg.sv - shared states, start-pulse lengths and frame checksum for dht_sensor_ctrl
package dht_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START_LOW = 3'd1;
  localparam logic [2:0] ST_START_REL = 3'd2;
  localparam logic [2:0] ST_RESP_LOW  = 3'd3;
  localparam logic [2:0] ST_RESP_HIGH = 3'd4;
  localparam logic [2:0] ST_BIT_LOW   = 3'd5;
  localparam logic [2:0] ST_BIT_HIGH  = 3'd6;
  localparam logic [2:0] ST_DONE      = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE      = ST_IDLE,
    S_START_LOW = ST_START_LOW,
    S_START_REL = ST_START_REL,
    S_RESP_LOW  = ST_RESP_LOW,
    S_RESP_HIGH = ST_RESP_HIGH,
    S_BIT_LOW   = ST_BIT_LOW,
    S_BIT_HIGH  = ST_BIT_HIGH,
    S_DONE      = ST_DONE
  } dht_state_e;

  localparam int START_US_DHT11 = 18000;
  localparam int START_US_DHT22 = 1000;

  // Wide enough for the 18 ms DHT11 start pulse.
  localparam int US_W = 15;

  localparam int DHT_MAX_BYTES = 16;
  localparam int DHT_MAX_BITS  = 8 * DHT_MAX_BYTES;

  // Byte 0 (last on the wire) must equal the mod-256 sum of the other bytes.
  function automatic logic dht_checksum_ok(input logic [DHT_MAX_BITS-1:0] frame,
                                           input int nbytes);
    logic [7:0] sum;
    sum = 8'd0;
    for (int i = 1; i < DHT_MAX_BYTES; i++) begin
      if (i < nbytes) sum = sum + frame[8*i +: 8];
    end
    return sum == frame[7:0];
  endfunction

endpackage

// File: rtl/dht_us_tick.sv
// rtl/dht_us_tick.sv - free-running one-cycle pulse every microsecond
module dht_us_tick #(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  // Clocks at or below 1 MHz simply tick every cycle.
  localparam int DIV = (CLK_HZ >= 2_000_000) ? CLK_HZ / 1_000_000 : 1;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dht_sensor_ctrl.sv
// rtl/dht_sensor_ctrl.sv - DHT11/DHT22 single-wire read controller with per-phase timeouts
// Define DHT_CHECKSUM_EN to qualify valid with the frame checksum and report chk_err.
module dht_sensor_ctrl
  import dht_pkg::*;
#(
  parameter int CLK_HZ        = 100_000_000,
  parameter int NBYTES        = 5,
  parameter int BIT_THRESH_US = 40,
  parameter int TIMEOUT_US    = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                mode,
  inout  wire                 dht_io,
  output logic [8*NBYTES-1:0] dht_data,
  output logic                valid,
  output logic                done,
  output logic                busy,
  output logic                timeout_err,
  output logic                chk_err,
  output logic [2:0]          state
);

  localparam int NBITS = 8 * NBYTES;
  localparam int BCW   = $clog2(NBITS + 1);
  localparam logic [US_W-1:0] US_MAX = '1;

  logic             tick;
  logic             io_s1, io_s2, io_s3;
  logic             start_d;
  logic             drive_low;
  logic             mode_q;
  logic [US_W-1:0]  us_cnt;
  logic [US_W-1:0]  start_len;
  logic [NBITS-1:0] shift_q;
  logic [NBITS-1:0] shift_nxt;
  logic [BCW-1:0]   bit_cnt;
  logic [2:0]       state_nxt;
  logic             rise, fall, start_rise;
  logic             bit_val, timed_phase, phase_timeout;
  logic             finish_frame, finish_to;
  logic             sum_ok;

  dht_us_tick #(
    .CLK_HZ(CLK_HZ)
  ) u_us_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  assign dht_io = drive_low ? 1'b0 : 1'bz;

  assign rise       = io_s2 & ~io_s3;
  assign fall       = ~io_s2 & io_s3;
  assign start_rise = start & ~start_d;

  assign start_len     = mode_q ? US_W'(START_US_DHT22) : US_W'(START_US_DHT11);
  assign bit_val       = (us_cnt > US_W'(BIT_THRESH_US));
  assign shift_nxt     = {shift_q[NBITS-2:0], bit_val};
  assign timed_phase   = (state >= ST_START_REL) && (state <= ST_BIT_HIGH);
  assign phase_timeout = (us_cnt >= US_W'(TIMEOUT_US));

`ifdef DHT_CHECKSUM_EN
  assign sum_ok = dht_checksum_ok(DHT_MAX_BITS'(shift_nxt), NBYTES);
`else
  assign sum_ok = 1'b1;
`endif

  always_comb begin
    state_nxt    = state;
    finish_frame = 1'b0;
    finish_to    = 1'b0;
    case (state)
      ST_IDLE:      if (start_rise) state_nxt = ST_START_LOW;
      ST_START_LOW: if (us_cnt >= start_len - 1'b1) state_nxt = ST_START_REL;
      ST_START_REL: if (fall) state_nxt = ST_RESP_LOW;
      ST_RESP_LOW:  if (rise) state_nxt = ST_RESP_HIGH;
      ST_RESP_HIGH: if (fall) state_nxt = ST_BIT_LOW;
      ST_BIT_LOW:   if (rise) state_nxt = ST_BIT_HIGH;
      ST_BIT_HIGH: begin
        if (fall) begin
          if (bit_cnt == BCW'(NBITS - 1)) begin
            state_nxt    = ST_DONE;
            finish_frame = 1'b1;
          end else begin
            state_nxt = ST_BIT_LOW;
          end
        end
      end
      ST_DONE:      state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
    // A line edge arriving in the same cycle as the timeout wins.
    if (timed_phase && phase_timeout && (state_nxt == state)) begin
      state_nxt = ST_DONE;
      finish_to = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      io_s1       <= 1'b1;
      io_s2       <= 1'b1;
      io_s3       <= 1'b1;
      start_d     <= 1'b1;
      drive_low   <= 1'b0;
      mode_q      <= 1'b0;
      us_cnt      <= '0;
      shift_q     <= '0;
      bit_cnt     <= '0;
      state       <= ST_IDLE;
      dht_data    <= '0;
      valid       <= 1'b0;
      done        <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      chk_err     <= 1'b0;
    end else begin
      io_s1     <= dht_io;
      io_s2     <= io_s1;
      io_s3     <= io_s2;
      start_d   <= start;
      state     <= state_nxt;
      drive_low <= (state_nxt == ST_START_LOW);
      done      <= finish_frame | finish_to;

      if (state_nxt != state) begin
        us_cnt <= '0;
      end else if (tick && (us_cnt != US_MAX)) begin
        us_cnt <= us_cnt + 1'b1;
      end

      if ((state == ST_IDLE) && start_rise) begin
        mode_q      <= mode;
        valid       <= 1'b0;
        timeout_err <= 1'b0;
        chk_err     <= 1'b0;
        busy        <= 1'b1;
        bit_cnt     <= '0;
      end

      if ((state == ST_BIT_HIGH) && fall) begin
        shift_q <= shift_nxt;
        bit_cnt <= bit_cnt + 1'b1;
      end

      if (finish_frame) begin
        dht_data <= shift_nxt;
        valid    <= sum_ok;
        chk_err  <= ~sum_ok;
        busy     <= 1'b0;
      end

      if (finish_to) begin
        timeout_err <= 1'b1;
        valid       <= 1'b0;
        busy        <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dht_sensor_ctrl.sv
// tb/tb_dht_sensor_ctrl.sv - self-checking bench for dht_sensor_ctrl (1 MHz clock, 5- and 3-byte frames)
module tb_dht_sensor_ctrl;
  import dht_pkg::*;

`ifdef DHT_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  typedef struct {
    logic        mode;
    logic [39:0] frame;
    int          one_w;
    int          zero_w;
    logic [39:0] exp_data;
    logic        exp_valid;
    logic        exp_chk;
    int          exp_low;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n, start_a, start_b, mode, sens_a, sens_b;
  wire  line_a, line_b;

  logic [39:0] data_a;
  logic [23:0] data_b;
  logic valid_a, done_a, busy_a, to_a, chk_a;
  logic valid_b, done_b, busy_b, to_b, chk_b;
  logic [2:0] state_a, state_b;

  int checks = 0;
  int errors = 0;
  int hw[40];

  int          done_cnt_a = 0;
  int          done_cnt_b = 0;
  logic [39:0] cap_data_a;
  logic [23:0] cap_data_b;
  logic        cap_valid_a, cap_chk_a, cap_to_a, cap_valid_b;

  always #5 clk = ~clk;

  pullup (line_a);
  pullup (line_b);
  assign line_a = sens_a ? 1'b0 : 1'bz;
  assign line_b = sens_b ? 1'b0 : 1'bz;

  dht_sensor_ctrl #(
    .CLK_HZ(1_000_000), .NBYTES(5), .BIT_THRESH_US(40), .TIMEOUT_US(255)
  ) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .mode(mode), .dht_io(line_a),
    .dht_data(data_a), .valid(valid_a), .done(done_a), .busy(busy_a),
    .timeout_err(to_a), .chk_err(chk_a), .state(state_a)
  );

  dht_sensor_ctrl #(
    .CLK_HZ(1_000_000), .NBYTES(3), .BIT_THRESH_US(40), .TIMEOUT_US(255)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .mode(mode), .dht_io(line_b),
    .dht_data(data_b), .valid(valid_b), .done(done_b), .busy(busy_b),
    .timeout_err(to_b), .chk_err(chk_b), .state(state_b)
  );

  always @(negedge clk) begin
    if (done_a) begin
      done_cnt_a  <= done_cnt_a + 1;
      cap_data_a  <= data_a;
      cap_valid_a <= valid_a;
      cap_chk_a   <= chk_a;
      cap_to_a    <= to_a;
    end
    if (done_b) begin
      done_cnt_b  <= done_cnt_b + 1;
      cap_data_b  <= data_b;
      cap_valid_b <= valid_b;
    end
  end

  initial begin
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d want %0d..%0d", name, act, lo, hi);
    end
  endtask

  function automatic bit line_hi(input bit sel);
    return sel ? line_b : line_a;
  endfunction

  task automatic pull(input bit sel, input bit v);
    if (sel) sens_b = v;
    else     sens_a = v;
  endtask

  // Reference: valid/chk_err follow from the byte sum alone.
  function automatic void ref_model(input logic [39:0] f, input int nb,
                                    output logic v, output logic ce);
    int s;
    s = 0;
    for (int k = 1; k < nb; k++) s += int'(f[8*k +: 8]);
    if (CK_EN) begin
      v  = ((s % 256) == int'(f[7:0]));
      ce = !v;
    end else begin
      v  = 1'b1;
      ce = 1'b0;
    end
  endfunction

  function automatic void set_widths(input logic [39:0] f, input int nbits,
                                     input int one_w, input int zero_w);
    for (int i = 0; i < nbits; i++) begin
      if (f[nbits-1-i]) hw[i] = (one_w != 0) ? one_w : int'($urandom_range(70, 45));
      else              hw[i] = (one_w != 0) ? zero_w : int'($urandom_range(38, 18));
    end
  endfunction

  task automatic sensor_reply(input bit sel, input int nbits, output int low_us);
    int t;
    t = 0;
    while (line_hi(sel) && t < 20000) begin
      @(negedge clk);
      t++;
    end
    chk("host_pulls_low", 64'(t < 20000), 64'd1);
    low_us = 0;
    while (!line_hi(sel) && low_us < 20000) begin
      @(negedge clk);
      low_us++;
    end
    repeat (20) @(negedge clk);
    pull(sel, 1'b1); repeat (80) @(negedge clk);
    pull(sel, 1'b0); repeat (80) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      pull(sel, 1'b1); repeat (50) @(negedge clk);
      pull(sel, 1'b0); repeat (hw[i]) @(negedge clk);
    end
    pull(sel, 1'b1); repeat (50) @(negedge clk);
    pull(sel, 1'b0);
  endtask

  task automatic read_a(input logic m, output int low_us, output int d0);
    d0 = done_cnt_a;
    @(negedge clk);
    mode    = m;
    start_a = 1'b1;
    sensor_reply(1'b0, 40, low_us);
    repeat (5) @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic check_a(input string tag, input logic [39:0] ed, input logic ev,
                         input logic ec, input int el, input int low_us, input int d0);
    chk_range({tag, "_start_low"}, low_us, el - 1, el + 1);
    chk({tag, "_done_pulses"}, 64'(done_cnt_a - d0), 64'd1);
    chk({tag, "_data"}, 64'(cap_data_a), 64'(ed));
    chk({tag, "_valid"}, 64'(cap_valid_a), 64'(ev));
    chk({tag, "_chk_err"}, 64'(cap_chk_a), 64'(ec));
    chk({tag, "_timeout"}, 64'(cap_to_a), 64'd0);
    chk({tag, "_busy_after"}, 64'(busy_a), 64'd0);
    chk({tag, "_state_idle"}, 64'(state_a), 64'(ST_IDLE));
  endtask

  initial begin
    vec_t        vecs[4];
    int          low, d0, t;
    logic [39:0] f, last_frame_a;
    logic [7:0]  b;
    logic        ev, ec;
    int          s;

    vecs[0] = '{1'b0, 40'h37001A0051, 68, 29, 40'h37001A0051, 1'b1, 1'b0, 18000};
    vecs[1] = '{1'b1, 40'h37001A0051, 68, 29, 40'h37001A0051, 1'b1, 1'b0, 1000};
    vecs[2] = '{1'b1, 40'hAA0FC4007F, 68, 29, 40'hAA0FC4007F, !CK_EN, CK_EN, 1000};
    vecs[3] = '{1'b1, 40'hF00F55AAFE, 42, 40, 40'hF00F55AAFE, 1'b1, 1'b0, 1000};

    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; mode = 1'b0;
    sens_a = 1'b0; sens_b = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_state", 64'(state_a), 64'(ST_IDLE));
    chk("rst_data", 64'(data_a), 64'd0);
    chk("rst_valid", 64'(valid_a), 64'd0);
    chk("rst_done", 64'(done_a), 64'd0);
    chk("rst_busy", 64'(busy_a), 64'd0);
    chk("rst_timeout", 64'(to_a), 64'd0);
    chk("rst_chk_err", 64'(chk_a), 64'd0);
    chk("rst_line_released", 64'(line_a), 64'd1);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      set_widths(vecs[i].frame, 40, vecs[i].one_w, vecs[i].zero_w);
      read_a(vecs[i].mode, low, d0);
      check_a($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_valid,
              vecs[i].exp_chk, vecs[i].exp_low, low, d0);
      last_frame_a = vecs[i].frame;
    end

    for (int r = 0; r < 3; r++) begin
      s = 0;
      f = '0;
      for (int k = 4; k >= 1; k--) begin
        b = 8'($urandom);
        f[8*k +: 8] = b;
        s += int'(b);
      end
      f[7:0] = ($urandom_range(1, 0) == 1) ? 8'(s) : 8'($urandom);
      ref_model(f, 5, ev, ec);
      set_widths(f, 40, 0, 0);
      read_a(1'b1, low, d0);
      check_a($sformatf("rand%0d", r), f, ev, ec, 1000, low, d0);
      last_frame_a = f;
    end

    // Sensor silent after release: expect a timeout about 255 us later.
    d0 = done_cnt_a;
    @(negedge clk);
    mode = 1'b1; start_a = 1'b1;
    t = 0;
    while (line_a && t < 100) begin @(negedge clk); t++; end
    t = 0;
    while (!line_a && t < 2000) begin @(negedge clk); t++; end
    t = 0;
    while (!done_a && t < 400) begin @(negedge clk); t++; end
    chk_range("to_latency", t, 254, 258);
    chk("to_flag", 64'(to_a), 64'd1);
    chk("to_valid", 64'(valid_a), 64'd0);
    chk("to_data_kept", 64'(data_a), 64'(last_frame_a));
    @(negedge clk);
    chk("to_busy_dropped", 64'(busy_a), 64'd0);
    chk("to_done_pulses", 64'(done_cnt_a - d0), 64'd1);
    start_a = 1'b0;
    repeat (3) @(negedge clk);

    // Second start while busy is ignored; then reset during BIT_HIGH.
    @(negedge clk);
    mode = 1'b1; start_a = 1'b1;
    t = 0;
    repeat (500) begin @(negedge clk); t++; end
    start_a = 1'b0;
    @(negedge clk); t++;
    start_a = 1'b1;
    chk("busy_mid_start", 64'(busy_a), 64'd1);
    while (!line_a && t < 3000) begin @(negedge clk); t++; end
    chk_range("second_start_ignored", t, 1000, 1003);
    repeat (20) @(negedge clk);
    sens_a = 1'b1; repeat (80) @(negedge clk);
    sens_a = 1'b0; repeat (80) @(negedge clk);
    sens_a = 1'b1; repeat (50) @(negedge clk);
    sens_a = 1'b0; repeat (10) @(negedge clk);
    chk("in_bit_high", 64'(state_a), 64'(ST_BIT_HIGH));
    rst_n = 1'b0;
    #1;
    chk("rst_mid_state", 64'(state_a), 64'(ST_IDLE));
    chk("rst_mid_line", 64'(line_a), 64'd1);
    chk("rst_mid_busy", 64'(busy_a), 64'd0);
    chk("rst_mid_data", 64'(data_a), 64'd0);
    chk("rst_mid_flags", 64'({valid_a, done_a, to_a, chk_a}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    start_a = 1'b0;
    repeat (3) @(negedge clk);

    // Three-byte instance.
    f = 40'h0000102030;
    ref_model(f, 3, ev, ec);
    set_widths(f, 24, 68, 29);
    d0 = done_cnt_b;
    @(negedge clk);
    mode = 1'b1; start_b = 1'b1;
    sensor_reply(1'b1, 24, low);
    repeat (5) @(negedge clk);
    start_b = 1'b0;
    chk_range("b_start_low", low, 999, 1001);
    chk("b_done_pulses", 64'(done_cnt_b - d0), 64'd1);
    chk("b_data", 64'(cap_data_b), 64'h102030);
    chk("b_valid", 64'(cap_valid_b), 64'(ev));
    chk("b_model_valid", 64'(ev), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
